// File: rtl/adc_scan_pkg.sv
// rtl/adc_scan_pkg.sv - shared types and sizes for the ADC scan sequencer
package adc_scan_pkg;

  localparam int NUM_CH   = 8;
  localparam int DATA_W   = 12;
  localparam int ADDR_W   = 3;
  localparam int AVG_LOG2 = 2;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    START,
    WAIT,
    STORE
  } state_e;

endpackage

// File: rtl/chan_rr_pick.sv
// rtl/chan_rr_pick.sv - next set mask bit strictly above cur_i, wrapping; wrap_o when pick <= cur
module chan_rr_pick
  import adc_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [ADDR_W-1:0] cur_i,
  output logic [ADDR_W-1:0] pick_o,
  output logic              found_o,
  output logic              wrap_o
);

  logic [ADDR_W-1:0] idx;

  // i == NUM_CH lands back on cur_i, so a lone mask bit reselects itself
  always_comb begin
    pick_o  = cur_i;
    found_o = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = cur_i + ADDR_W'(i);
      if (!found_o && mask_i[idx]) begin
        pick_o  = idx;
        found_o = 1'b1;
      end
    end
    wrap_o = found_o && (pick_o <= cur_i);
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - round-robin ADC channel scanner with result registers
// Optional 4x averaging per channel when SCAN_AVG_EN is defined.
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              enable,
  input  logic [NUM_CH-1:0] channel_mask,
  output logic [ADDR_W-1:0] adc_addr,
  output logic              conv_start,
  input  logic              conv_done,
  input  logic [DATA_W-1:0] conv_data,
  input  logic [ADDR_W-1:0] rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              sample_valid,
  output logic [ADDR_W-1:0] sample_ch,
  output logic              scan_done,
  output logic              timeout_err
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              restart_q, restart_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              tout_q, tout_d;
  logic [DATA_W-1:0] result_q [NUM_CH];

`ifdef SCAN_AVG_EN
  logic [DATA_W+AVG_LOG2-1:0] acc_q, acc_d, acc_sum;
  logic [AVG_LOG2-1:0]        beat_q, beat_d;
`endif

  logic [ADDR_W-1:0] pick;
  logic              found, wrap;

  // After IDLE the search base is the top channel so the lowest set bit wins
  chan_rr_pick u_pick (
    .mask_i  (channel_mask),
    .cur_i   (restart_q ? ADDR_W'(NUM_CH - 1) : addr_q),
    .pick_o  (pick),
    .found_o (found),
    .wrap_o  (wrap)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    addr_d       = addr_q;
    restart_d    = restart_q;
    data_d       = data_q;
    tout_d       = tout_q;
    conv_start   = 1'b0;
    sample_valid = 1'b0;
    scan_done    = 1'b0;
`ifdef SCAN_AVG_EN
    acc_d   = acc_q;
    beat_d  = beat_q;
    acc_sum = acc_q + {{AVG_LOG2{1'b0}}, conv_data};
`endif
    case (state_q)
      IDLE: begin
        restart_d = 1'b1;
        if (enable && |channel_mask) state_d = SELECT;
      end
      SELECT: begin
        if (enable && found) begin
          addr_d    = pick;
          restart_d = 1'b0;
          scan_done = wrap && !restart_q;
          state_d   = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (!enable)                  state_d = IDLE;
        else if (cnt_q == SETTLE_LAST) state_d = START;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      START: begin
        conv_start = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (conv_done) begin
`ifdef SCAN_AVG_EN
          if (beat_q == '1) begin
            data_d  = acc_sum[DATA_W+AVG_LOG2-1:AVG_LOG2];
            acc_d   = '0;
            beat_d  = '0;
            state_d = STORE;
          end else begin
            acc_d   = acc_sum;
            beat_d  = beat_q + 1'b1;
            state_d = START;
          end
`else
          data_d  = conv_data;
          state_d = STORE;
`endif
        end else if (cnt_q == TIMEOUT_LAST) begin
          tout_d  = 1'b1;
          state_d = SELECT;
`ifdef SCAN_AVG_EN
          acc_d  = '0;
          beat_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STORE: begin
        sample_valid = 1'b1;
        state_d      = (enable && |channel_mask) ? SELECT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      restart_q <= 1'b1;
      data_q    <= '0;
      tout_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) result_q[i] <= '0;
`ifdef SCAN_AVG_EN
      acc_q  <= '0;
      beat_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      restart_q <= restart_d;
      data_q    <= data_d;
      tout_q    <= tout_d;
      if (state_q == STORE) result_q[addr_q] <= data_q;
`ifdef SCAN_AVG_EN
      acc_q  <= acc_d;
      beat_q <= beat_d;
`endif
    end
  end

  assign adc_addr    = addr_q;
  assign sample_ch   = (state_q == STORE) ? addr_q : '0;
  assign timeout_err = tout_q;
  assign rd_data     = result_q[rd_ch];

endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: idle cycles between an address change and conversion start.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles to wait for conv_done.
REQ-003 SHALL have port clk, in, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port Resetn, in, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable, in, 1: level; 1 = scan continuously.
REQ-006 SHALL have port channel_mask, in, 8: bit n = channel n is included in the scan.
REQ-007 SHALL have port adc_addr, out, 3: channel address driven to the SPI converter.
REQ-008 SHALL have port conv_start, out, 1: one-cycle conversion request pulse.
REQ-009 SHALL have port conv_done, in, 1: one-cycle pulse; conv_data is valid in that cycle.
REQ-010 SHALL have port conv_data, in, 12: raw ADC sample.
REQ-011 SHALL have port rd_ch, in, 3: result register select.
REQ-012 SHALL have port rd_data, out, 12: combinational read of result[rd_ch].
REQ-013 SHALL have port sample_valid, out, 1: one-cycle pulse on each result update.
REQ-014 SHALL have port sample_ch, out, 3: channel of the current sample_valid pulse.
REQ-015 SHALL have port scan_done, out, 1: one-cycle pulse when the scan wraps from the highest to the lowest enabled channel.
REQ-016 SHALL have port timeout_err, out, 1: sticky; cleared only by reset.

Function
REQ-017 SHALL implement FSM states IDLE, SELECT, SETTLE, START, WAIT, STORE.
REQ-018 IDLE -> SELECT when enable=1 and channel_mask!=0; otherwise SHALL remain in IDLE.
REQ-019 SELECT SHALL sample channel_mask, choose the next set bit strictly above the current channel (wrapping 7->0), load adc_addr, then go to SETTLE.
REQ-020 With exactly one mask bit set, SELECT SHALL reselect that same channel.
REQ-021 SETTLE SHALL count SETTLE_CYCLES cycles, then go to START; when SETTLE_CYCLES=0 it SHALL pass through in one cycle.
REQ-022 START SHALL assert conv_start for exactly one cycle, then go to WAIT.
REQ-023 In WAIT, conv_done SHALL cause conv_data to be captured and the FSM to go to STORE.
REQ-024 In WAIT, reaching TIMEOUT_CYCLES without conv_done SHALL set timeout_err, leave results unchanged, and go to SELECT.
REQ-025 conv_done outside WAIT SHALL be ignored.
REQ-026 STORE SHALL write result[adc_addr] and pulse sample_valid/sample_ch in the same cycle, exactly 1 cycle after the accepted conv_done.
REQ-027 STORE SHALL go to SELECT if enable=1 and mask!=0; otherwise to IDLE.
REQ-028 If enable falls during SETTLE or WAIT, the current conversion SHALL complete (or time out) before the FSM enters IDLE; conv_start SHALL never be issued after enable=0 has been seen in SETTLE.
REQ-029 Mask changes SHALL take effect only at the next SELECT.
REQ-030 scan_done SHALL pulse in the SELECT cycle in which the chosen channel is less than or equal to the previous channel.
REQ-031 When returning from IDLE, the scan SHALL restart at the lowest set mask bit.

Reset
REQ-032 On Resetn=0 the block SHALL immediately enter IDLE with: adc_addr=0, conv_start=0, sample_valid=0, sample_ch=0, scan_done=0, timeout_err=0, all results=0, all counters=0.
REQ-033 Reset mid-conversion SHALL abort without a stored sample; any late conv_done SHALL be ignored.

Configuration
REQ-034 Macro SCAN_AVG_EN SHALL select the averaging feature at compile time.
REQ-035 With SCAN_AVG_EN defined: each selected channel SHALL be converted 4 times consecutively (SETTLE before the first only), summed in a 14-bit accumulator, and stored as sum>>2; sample_valid SHALL pulse only after the 4th sample; a timeout SHALL discard the partial sum.
REQ-036 Without SCAN_AVG_EN: one conversion per channel, stored unmodified, and no accumulator logic.

Structure
REQ-037 Package adc_scan_pkg SHALL hold the state enum, NUM_CH=8, DATA_W=12, ADDR_W=3, AVG_LOG2=2.
REQ-038 Sub-module chan_rr_pick (combinational next-set-bit round-robin finder with a wrap flag) SHALL be used by SELECT.

Verification
REQ-039 mask=8'h05, enable=1, ADC model returns 12'h123 (ch0) and 12'hABC (ch2) -> adc_addr sequence 0,2,0,2; sample_valid 1 cycle after each conv_done; scan_done on each 2->0 wrap; rd_ch=2 reads 12'hABC.
REQ-040 mask=0 with enable=1 -> FSM stays IDLE and conv_start is never asserted.
REQ-041 ADC model withholds conv_done on ch3 -> timeout_err=1 after 1024 WAIT cycles, result[3] unchanged, scan proceeds to the next channel.
REQ-042 enable dropped during WAIT -> that sample is stored, then IDLE with no further conv_start; Resetn pulsed in WAIT -> all outputs 0 and a late conv_done is ignored.
REQ-043 SCAN_AVG_EN defined, ch1 samples 100,101,102,103 -> a single sample_valid with result[1]=101.
